// File: rtl/lfsr_sync_checker_pkg.sv
// Shared LFSR definitions: word width, canonical seed, checker states and the step function.
// The generator and checker both call lfsr_step, so one edit here keeps them in agreement.
package lfsr_pkg;

  localparam int LFSR_W = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 4'hE;

  // Checker states, encoded to stay compatible with legacy state dumps
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[2:0], cur[3] ^ cur[1]};
  endfunction

endpackage

// File: rtl/lfsr_sync_checker_if.sv
// Pattern stream into the checker and its registered status back out.
// The zero_o status signal exists only when LFSR_CHK_ZERO_DET_EN is defined.
interface lfsr_sync_checker_if
  import lfsr_pkg::*;
#(
  parameter int CNT_W = 8
);
  logic              valid_i;
  logic [LFSR_W-1:0] data_i;
  logic              locked_o;
  logic              err_o;
  logic [CNT_W-1:0]  err_cnt_o;
  logic [LFSR_W-1:0] exp_o;
`ifdef LFSR_CHK_ZERO_DET_EN
  logic              zero_o;
`endif

  modport master (
`ifdef LFSR_CHK_ZERO_DET_EN
    input  zero_o,
`endif
    output valid_i, data_i,
    input  locked_o, err_o, err_cnt_o, exp_o
  );

  modport slave (
`ifdef LFSR_CHK_ZERO_DET_EN
    output zero_o,
`endif
    input  valid_i, data_i,
    output locked_o, err_o, err_cnt_o, exp_o
  );
endinterface

// File: rtl/lfsr_sync_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; the count changes on the edge after inc/clear.
// No backpressure: inc is taken every cycle it is high, and the counter parks at all-ones.
module lfsr_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_sync_checker.sv
// Locks onto the 4-bit LFSR pattern stream, flywheels it and counts mismatches; all outputs update one edge after the beat.
// No backpressure: every valid beat is consumed. Zero-word detect is built when LFSR_CHK_ZERO_DET_EN is defined.
module lfsr_sync_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_THRESH = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  lfsr_sync_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_T = 4'(LOCK_THRESH);
  localparam logic [3:0] LOSS_T = 4'(LOSS_THRESH);

  logic [1:0]        state_q;
  logic [LFSR_W-1:0] exp_q;
  logic [3:0]        match_cnt;
  logic [3:0]        miss_cnt;
  logic              locked_q;
  logic              err_q;
  logic              zero_w;
  logic              beat_miss;
  logic              err_inc;
  logic [CNT_W-1:0]  err_cnt;

`ifdef LFSR_CHK_ZERO_DET_EN
  logic zero_q;

  assign zero_w = (bus.data_i == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b0;
    end else if (clear_i) begin
      zero_q <= 1'b0;
    end else if (bus.valid_i && zero_w) begin
      zero_q <= 1'b1;
    end
  end

  assign bus.zero_o = zero_q;
`else
  assign zero_w = 1'b0;
`endif

  // A zero word can never be a valid pattern beat when detection is enabled
  assign beat_miss = (bus.data_i != exp_q) | zero_w;
  assign err_inc   = bus.valid_i & ~clear_i & (state_q == LOCKED) & beat_miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.valid_i) begin
        case (state_q)
          IDLE: begin
            if (!zero_w) begin
              exp_q     <= lfsr_step(bus.data_i);
              match_cnt <= '0;
              state_q   <= SEARCH;
            end
          end
          SEARCH: begin
            if (!zero_w) begin
              if (!beat_miss) begin
                exp_q <= lfsr_step(exp_q);
                if (match_cnt + 4'd1 == LOCK_T) begin
                  state_q   <= LOCKED;
                  locked_q  <= 1'b1;
                  match_cnt <= '0;
                  miss_cnt  <= '0;
                end else begin
                  match_cnt <= match_cnt + 4'd1;
                end
              end else begin
                match_cnt <= '0;
                exp_q     <= lfsr_step(bus.data_i);
              end
            end
          end
          LOCKED: begin
            if (beat_miss) begin
              err_q <= 1'b1;
              // Lock is lost on the Nth miss; resume the search from this word
              if (miss_cnt + 4'd1 == LOSS_T) begin
                state_q   <= SEARCH;
                locked_q  <= 1'b0;
                match_cnt <= '0;
                miss_cnt  <= '0;
                exp_q     <= lfsr_step(bus.data_i);
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
                exp_q    <= lfsr_step(exp_q);
              end
            end else begin
              miss_cnt <= '0;
              exp_q    <= lfsr_step(exp_q);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  lfsr_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear_i),
    .inc   (err_inc),
    .cnt   (err_cnt)
  );

  assign bus.locked_o  = locked_q;
  assign bus.err_o     = err_q;
  assign bus.err_cnt_o = err_cnt;
  assign bus.exp_o     = exp_q;

endmodule
